// File: rtl/ac3_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ac3_pkg
// Purpose : Shared definitions for the AC3 accumulation stage: controller
//           state encoding, accumulator width helper and default job size.
// Ports   : none (package)
// Rev     : 1.0 - initial release
// ============================================================================
package ac3_pkg;

  // Default maximum operand count per job (3x3xN_filter_max/16).
  localparam int unsigned AC3_MNO_DEFAULT = 288;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_OUT   = 2'd2
  } ac3_state_e;

  // Accumulator width: multiplier fan-in growth + product width + operand
  // count growth + one guard bit, so a legal job can never wrap.
  function automatic int unsigned ac3_acc_width(input int unsigned m,
                                                input int unsigned pa,
                                                input int unsigned pw,
                                                input int unsigned mno);
    return $clog2(m) + pa + pw + $clog2(mno) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ac3_adder.sv
`default_nettype none
// ============================================================================
// Module  : ac3_adder
// Purpose : AC3 accumulate adder, adds the AC2 partial sum to the value held
//           in the accumulator register. Purely combinational, modulo 2^W.
// Ports   : in_from_ac2 [W] - partial sum from the AC2 tree
//           in_from_reg [W] - current accumulator contents
//           sum_out     [W] - in_from_ac2 + in_from_reg
// Rev     : 1.0 - initial release
// ============================================================================
module ac3_adder #(
  parameter int unsigned W = 26
) (
  input  logic [W-1:0] in_from_ac2,
  input  logic [W-1:0] in_from_reg,
  output logic [W-1:0] sum_out
);

  assign sum_out = in_from_ac2 + in_from_reg;

endmodule
`default_nettype wire

// File: rtl/ac3_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ac3_accum_ctrl
// Purpose : AC3 sequencer. Accepts a job length, accumulates that many AC2
//           partial sums through ac3_adder into a wide register and presents
//           the final sum downstream with a valid/ready handshake.
// Ports   : clk, rst          - clock, synchronous active-high reset
//           start, num_ops    - job request and length (sampled in IDLE)
//           in_valid, in_data - AC2 partial sum stream
//           in_ready          - a beat is accepted when in_valid & in_ready
//           out_valid,out_data- final sum, held until out_ready
//           out_ready         - downstream accept
//           busy              - controller not idle
//           err               - one-cycle pulse after an illegal start
// Rev     : 1.0 - initial release
// ============================================================================
module ac3_accum_ctrl
  import ac3_pkg::*;
#(
  parameter  int unsigned M   = 16,
  parameter  int unsigned PA  = 8,
  parameter  int unsigned PW  = 4,
  parameter  int unsigned MNO = AC3_MNO_DEFAULT,
  localparam int unsigned W   = ac3_acc_width(M, PA, PW, MNO),
  localparam int unsigned CW  = $clog2(MNO + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] num_ops,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          err
);

  localparam logic [CW-1:0] MNO_C = CW'(MNO);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  ac3_state_e    state_q, state_d;
  logic [W-1:0]  acc_q,   acc_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [CW-1:0] len_q,   len_d;
  logic          err_q,   err_d;

  logic [W-1:0]  sum_w;
  logic          beat_w;
  logic          legal_w;

  ac3_adder #(
    .W (W)
  ) u_adder (
    .in_from_ac2 (in_data),
    .in_from_reg (acc_q),
    .sum_out     (sum_w)
  );

  // Beats only land while in ACCUM; in_ready is a pure state decode.
  assign beat_w  = in_valid & in_ready;
  assign legal_w = (num_ops != '0) && (num_ops <= MNO_C);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (legal_w) begin
            len_d   = num_ops;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ST_ACCUM;
          end else begin
            // Illegal length: flag it, leave the accumulator untouched.
            err_d = 1'b1;
          end
        end
      end
      ST_ACCUM: begin
        if (beat_w) begin
          acc_d = sum_w;
          cnt_d = cnt_q + ONE_C;
          // Last beat of the job: the sum is complete on the next cycle.
          if (cnt_q == len_q - ONE_C) begin
            state_d = ST_OUT;
          end
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_OUT);
  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;
  // Data is only meaningful with out_valid; hold it at zero otherwise.
  assign out_data  = out_valid ? acc_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_ac3_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_ac3_accum_ctrl
// Purpose : Self-checking bench for ac3_accum_ctrl. A job-level model tracks
//           the expected phase, remaining beats and running sum; every cycle
//           the DUT outputs are compared against it, and directed jobs pin
//           literal sums and latencies.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_ac3_accum_ctrl;

  localparam int W   = 26;
  localparam int CW  = 9;
  localparam int MNO = 288;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] num_ops = '0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready = 1'b0;
  logic          busy;
  logic          err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  ac3_accum_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_ops   (num_ops),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, got, exp);
    end
  endtask

  // ---------------- job-level model ----------------
  // phase: 0 idle, 1 collecting beats, 2 presenting result
  int     m_phase = 0;
  int     m_left  = 0;
  longint m_sum   = 0;
  bit     m_err   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_left  <= 0;
      m_sum   <= 0;
      m_err   <= 1'b0;
    end else begin
      m_err <= 1'b0;
      case (m_phase)
        0: if (start) begin
             if (num_ops >= 1 && num_ops <= MNO) begin
               m_phase <= 1;
               m_left  <= int'(num_ops);
               m_sum   <= 0;
             end else begin
               m_err <= 1'b1;
             end
           end
        1: if (in_valid) begin
             m_sum  <= m_sum + longint'(in_data);
             m_left <= m_left - 1;
             if (m_left == 1) m_phase <= 2;
           end
        2: if (out_ready) m_phase <= 0;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_in_ready",  64'(in_ready),  64'(m_phase == 1));
      chk("cmp_out_valid", 64'(out_valid), 64'(m_phase == 2));
      chk("cmp_busy",      64'(busy),      64'(m_phase != 0));
      chk("cmp_err",       64'(err),       64'(m_err));
      chk("cmp_out_data",  64'(out_data),  (m_phase == 2) ? 64'(m_sum[W-1:0]) : 64'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int n);
    start   = 1'b1;
    num_ops = CW'(n);
    tick();
    start   = 1'b0;
  endtask

  task automatic beat(input int d);
    in_valid = 1'b1;
    in_data  = W'(d);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string nm, input int maxc);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < maxc) begin
      tick();
      n++;
    end
    if (out_valid !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s timeout waiting for out_valid after %0d cycles", nm, maxc);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int vals[5];

    // Reset
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    tick();

    // Job 1: 4 beats back to back
    start_job(4);
    t0 = cyc;
    chk("j1_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = W'(10 * (i + 1));
      if (i == 3) chk("j1_not_early", 64'(out_valid), 64'd0);
      tick();
    end
    in_valid = 1'b0;
    chk("j1_latency",   64'(cyc - t0),  64'd4);
    chk("j1_out_valid", 64'(out_valid), 64'd1);
    chk("j1_sum",       64'(out_data),  64'd100);
    drain();
    chk("j1_busy_after", 64'(busy), 64'd0);
    tick();

    // Job 2: stalls interleaved; garbage data on stall cycles
    start_job(3);
    vals = '{5, 99, 7, 99, 9};
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = W'(vals[i]);
      tick();
    end
    in_valid = 1'b1;
    in_data  = W'(1000);
    chk("j2_out_valid", 64'(out_valid), 64'd1);
    chk("j2_sum",       64'(out_data),  64'd21);
    tick();
    chk("j2_no_extra",  64'(out_data),  64'd21);
    in_valid = 1'b0;
    drain();
    tick();

    // Illegal lengths
    start_job(0);
    chk("e0_err",   64'(err),      64'd1);
    chk("e0_busy",  64'(busy),     64'd0);
    chk("e0_ready", 64'(in_ready), 64'd0);
    tick();
    chk("e0_err_clear", 64'(err), 64'd0);
    start_job(MNO + 1);
    chk("e1_err",   64'(err),      64'd1);
    chk("e1_ready", 64'(in_ready), 64'd0);
    tick();
    chk("e1_err_clear", 64'(err), 64'd0);

    // Job 4: full-length job with large operands
    start_job(MNO);
    t0 = cyc;
    in_valid = 1'b1;
    in_data  = W'(65535);
    for (int i = 0; i < MNO; i++) begin
      if (i == MNO - 1) chk("j4_not_early", 64'(out_valid), 64'd0);
      tick();
    end
    in_valid = 1'b0;
    chk("j4_latency",   64'(cyc - t0),  64'd288);
    chk("j4_out_valid", 64'(out_valid), 64'd1);
    chk("j4_sum",       64'(out_data),  64'd18874080);
    drain();
    tick();

    // Job 5: back-pressure with start pulses that must be ignored
    start_job(2);
    beat(3);
    beat(4);
    for (int i = 0; i < 5; i++) begin
      start   = (i == 2);
      num_ops = CW'(1);
      chk("j5_hold", 64'(out_data), 64'd7);
      tick();
    end
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    chk("j5_idle_after", 64'(busy), 64'd0);
    tick();

    // Job 6: reset mid-job, then a single-operand job
    start_job(4);
    beat(1);
    beat(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("j6_abort_busy",  64'(busy),      64'd0);
    chk("j6_abort_valid", 64'(out_valid), 64'd0);
    tick();
    tick();
    start_job(1);
    beat(7);
    wait_out("j6_wait", 4);
    chk("j6_sum", 64'(out_data), 64'd7);
    drain();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
